fp_add_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor with valid/ready handshakes on both sides. It is the next-generation replacement for the team's combinational single-precision adder. It generalises exponent and mantissa width and adds an add/subtract mode, round-to-nearest-even with guard/round/sticky bits, full special-value handling, and status flags. It sits between an operand-issue stage and a result consumer, and accepts one operation per cycle when not stalled.

---
 rtl/fp_add_pipe.sv | 218 +++++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_pipe.sv
// Pipelined IEEE-754-style adder/subtractor: input capture, unpack/swap, align/add,
// normalise, round/pack. Parametrised exponent and fraction widths.
module fp_add_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 op,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic                 flag_ovf,
   output logic                 flag_inv,
   output logic                 flag_inx
);
   localparam int E  = EXP_W;
   localparam int M  = MAN_W;
   localparam int W  = 1 + E + M;
   localparam int XW = M + 4;
   localparam int SW = M + 5;
   localparam logic [W-1:0] QNAN     = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
   localparam logic [E-1:0] EXP_ONE  = E'(1);
   localparam logic [E:0]   EXPX_ONE = (E+1)'(1);
   localparam logic [E:0]   EXPX_MAX = {1'b0, {E{1'b1}}};

   // Handshake: a word moves on an edge where its valid and ready are both high. A result
   // held with out_ready low freezes every stage, so in_ready is simply the inverse of stall.
   logic stall;
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   logic v0, v1, v2, v3;
   logic [W-1:0] r0_a, r0_b;

   logic [E-1:0]   ea, eb;
   logic [M-1:0]   fa, fb;
   logic           a_nan, b_nan, a_inf, b_inf, swap, s1_inv;
   logic [W-1:0]   op_big, s1_spec;
   logic [W-2:0]   small_mag;
   logic [E-1:0]   big_e, small_e;

   assign ea        = r0_a[W-2:M];
   assign eb        = r0_b[W-2:M];
   assign fa        = r0_a[M-1:0];
   assign fb        = r0_b[M-1:0];
   assign a_nan     = (&ea) & (|fa);
   assign b_nan     = (&eb) & (|fb);
   assign a_inf     = (&ea) & ~(|fa);
   assign b_inf     = (&eb) & ~(|fb);
   assign swap      = r0_b[W-2:0] > r0_a[W-2:0];
   assign op_big    = swap ? r0_b : r0_a;
   assign small_mag = swap ? r0_a[W-2:0] : r0_b[W-2:0];
   assign big_e     = (|op_big[W-2:M]) ? op_big[W-2:M] : EXP_ONE;
   assign small_e   = (|small_mag[W-2:M]) ? small_mag[W-2:M] : EXP_ONE;

   always_comb begin
      s1_inv  = 1'b0;
      s1_spec = QNAN;
      if (a_nan | b_nan) begin
         s1_spec = QNAN;
      end else if (a_inf & b_inf & (r0_a[W-1] != r0_b[W-1])) begin
         s1_inv  = 1'b1;
      end else if (a_inf) begin
         s1_spec = r0_a;
      end else begin
         s1_spec = r0_b;
      end
   end

   logic           r1_sign, r1_sub, r1_zsign, r1_special, r1_inv;
   logic [E-1:0]   r1_exp, r1_diff;
   logic [M:0]     r1_sigb, r1_sigs;
   logic [W-1:0]   r1_spec;

   // Bits pushed past the low end of the extended significand collapse into sticky.
   logic [31:0]     sh2;
   logic [2*XW-1:0] s2_wide;
   logic [XW-1:0]   s2_small, s2_big;
   logic [SW-1:0]   s2_sum;

   always_comb begin
      sh2 = 32'(r1_diff);
      if (sh2 > 32'(M + 3)) sh2 = 32'(M + 3);
      s2_wide  = {r1_sigs, 3'b000, {XW{1'b0}}} >> sh2;
      s2_small = s2_wide[2*XW-1:XW] | {{(XW-1){1'b0}}, |s2_wide[XW-1:0]};
      s2_big   = {r1_sigb, 3'b000};
      s2_sum   = r1_sub ? ({1'b0, s2_big} - {1'b0, s2_small})
                        : ({1'b0, s2_big} + {1'b0, s2_small});
   end

   logic           r2_sign, r2_zsign, r2_special, r2_inv;
   logic [E-1:0]   r2_exp;
   logic [SW-1:0]  r2_sum;
   logic [W-1:0]   r2_spec;

   // Left shift stops at exponent 1; a hidden bit still clear afterwards marks a denormal.
   logic [31:0]    lz, lim, sh3;
   logic [XW-1:0]  s3_mant;
   logic [E:0]     s3_exp;

   always_comb begin
      lz = 32'(XW);
      for (int i = 0; i < XW; i++) begin
         if (r2_sum[i]) lz = 32'(XW - 1 - i);
      end
      lim = 32'(r2_exp) - 32'd1;
      sh3 = (lz < lim) ? lz : lim;
      if (r2_sum[SW-1]) begin
         s3_mant = {r2_sum[SW-1:2], r2_sum[1] | r2_sum[0]};
         s3_exp  = {1'b0, r2_exp} + EXPX_ONE;
      end else begin
         s3_mant = r2_sum[XW-1:0] << sh3;
         s3_exp  = {1'b0, r2_exp} - sh3[E:0];
      end
   end

   logic           r3_sign, r3_zsign, r3_special, r3_inv;
   logic [E:0]     r3_exp;
   logic [XW-1:0]  r3_mant;
   logic [W-1:0]   r3_spec;

   logic           s4_inc, s4_hid, s4_ovf, s4_sign;
   logic [M+1:0]   s4_rnd;
   logic [M-1:0]   s4_frac;
   logic [E:0]     s4_exp;
   logic [W-1:0]   s4_res;
   logic           s4_flag_ovf, s4_flag_inv, s4_flag_inx;

   always_comb begin
      s4_inc = r3_mant[2] & (r3_mant[1] | r3_mant[0] | r3_mant[3]);
      s4_rnd = {1'b0, r3_mant[XW-1:3]} + {{(M+1){1'b0}}, s4_inc};
      if (s4_rnd[M+1]) begin
         s4_hid  = 1'b1;
         s4_frac = s4_rnd[M:1];
         s4_exp  = r3_exp + EXPX_ONE;
      end else begin
         s4_hid  = s4_rnd[M];
         s4_frac = s4_rnd[M-1:0];
         s4_exp  = r3_exp;
      end
      s4_ovf  = s4_hid & (s4_exp >= EXPX_MAX);
      s4_sign = (s4_rnd == '0) ? r3_zsign : r3_sign;
      if (r3_special) begin
         s4_res      = r3_spec;
         s4_flag_ovf = 1'b0;
         s4_flag_inv = r3_inv;
         s4_flag_inx = 1'b0;
      end else begin
         s4_res      = s4_ovf ? {r3_sign, {E{1'b1}}, {M{1'b0}}}
                              : {s4_sign, s4_hid ? s4_exp[E-1:0] : {E{1'b0}}, s4_frac};
         s4_flag_ovf = s4_ovf;
         s4_flag_inv = 1'b0;
         s4_flag_inx = s4_ovf | (|r3_mant[2:0]);
      end
   end

   always_ff @(posedge clk) begin
      if (!stall) begin
         r0_a       <= a;
         r0_b       <= {b[W-1] ^ op, b[W-2:0]};
         r1_sign    <= op_big[W-1];
         r1_sub     <= r0_a[W-1] ^ r0_b[W-1];
         r1_zsign   <= r0_a[W-1] & r0_b[W-1];
         r1_special <= a_nan | b_nan | a_inf | b_inf;
         r1_inv     <= s1_inv;
         r1_spec    <= s1_spec;
         r1_exp     <= big_e;
         r1_diff    <= big_e - small_e;
         r1_sigb    <= {|op_big[W-2:M], op_big[M-1:0]};
         r1_sigs    <= {|small_mag[W-2:M], small_mag[M-1:0]};
         r2_sign    <= r1_sign;
         r2_zsign   <= r1_zsign;
         r2_special <= r1_special;
         r2_inv     <= r1_inv;
         r2_spec    <= r1_spec;
         r2_exp     <= r1_exp;
         r2_sum     <= s2_sum;
         r3_sign    <= r2_sign;
         r3_zsign   <= r2_zsign;
         r3_special <= r2_special;
         r3_inv     <= r2_inv;
         r3_spec    <= r2_spec;
         r3_exp     <= s3_exp;
         r3_mant    <= s3_mant;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v0        <= 1'b0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         flag_ovf  <= 1'b0;
         flag_inv  <= 1'b0;
         flag_inx  <= 1'b0;
      end else if (!stall) begin
         v0        <= in_valid;
         v1        <= v0;
         v2        <= v1;
         v3        <= v2;
         out_valid <= v3;
         if (v3) begin
            result   <= s4_res;
            flag_ovf <= s4_flag_ovf;
            flag_inv <= s4_flag_inv;
            flag_inx <= s4_flag_inx;
         end
      end
   end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: single precision instance plus a half precision instance,
// covering latency, rounding, limits, special values, backpressure and mid-stream reset.
module tb_fp_add_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, in_ready, op, out_valid, out_ready;
   logic        flag_ovf, flag_inv, flag_inx;
   logic [31:0] a, b, result;
   logic        h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready;
   logic        h_flag_ovf, h_flag_inv, h_flag_inx;
   logic [15:0] h_a, h_b, h_result;
   int errors = 0;
   int checks = 0;

   fp_add_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .flag_ovf(flag_ovf), .flag_inv(flag_inv), .flag_inx(flag_inx)
   );

   fp_add_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .op(h_op),
      .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result),
      .flag_ovf(h_flag_ovf), .flag_inv(h_flag_inv), .flag_inx(h_flag_inx)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_op(input logic [31:0] x, input logic [31:0] y, input logic o);
      in_valid = 1'b1;
      a        = x;
      b        = y;
      op       = o;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (!ok) begin
            if (out_valid) ok = 1'b1;
            else tick();
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
      checks++; if ({flag_ovf, flag_inv, flag_inx} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {flag_ovf, flag_inv, flag_inx}); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] va [3] = '{32'h40C00000, 32'h411C0000, 32'hC0C00000};
      logic [31:0] vb [3] = '{32'h41000000, 32'h3F100000, 32'h41000000};
      logic [31:0] vr [3] = '{32'h41600000, 32'h41250000, 32'h40000000};
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op        = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = va[i];
         b = vb[i];
         tick();
      end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early: got out_valid %b expected 0", out_valid); end
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, out_valid); end
         checks++; if (result !== vr[i]) begin errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, result, vr[i]); end
         checks++; if ({flag_ovf, flag_inv, flag_inx} !== 3'b000) begin errors++; $display("FAIL b2b_flags[%0d]: got %b expected 000", i, {flag_ovf, flag_inv, flag_inx}); end
         tick();
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail: got out_valid %b expected 0", out_valid); end
   endtask

   task automatic test_subtract();
      logic [31:0] va [2] = '{32'h3FCCCCCD, 32'h40400000};
      logic [31:0] vb [2] = '{32'h3F99999A, 32'h40400000};
      logic [31:0] vr [2] = '{32'h3ECCCCCC, 32'h00000000};
      bit ok;
      for (int i = 0; i < 2; i++) begin
         send_op(va[i], vb[i], 1'b1);
         wait_out(ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL sub_timeout[%0d]: got no out_valid expected one within 10 cycles", i);
         end else begin
            if (result !== vr[i]) begin errors++; $display("FAIL sub_result[%0d]: got %h expected %h", i, result, vr[i]); end
            checks++; if ({flag_ovf, flag_inv, flag_inx} !== 3'b000) begin errors++; $display("FAIL sub_flags[%0d]: got %b expected 000", i, {flag_ovf, flag_inv, flag_inx}); end
         end
         tick();
      end
   endtask

   task automatic test_rounding();
      logic [31:0] va [3] = '{32'h3F800000, 32'h7F7FFFFF, 32'h00000001};
      logic [31:0] vb [3] = '{32'h33800000, 32'h7F7FFFFF, 32'h00000001};
      logic [31:0] vr [3] = '{32'h3F800000, 32'h7F800000, 32'h00000002};
      logic [2:0]  vf [3] = '{3'b001, 3'b101, 3'b000};
      bit ok;
      for (int i = 0; i < 3; i++) begin
         send_op(va[i], vb[i], 1'b0);
         wait_out(ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL round_timeout[%0d]: got no out_valid expected one within 10 cycles", i);
         end else begin
            if (result !== vr[i]) begin errors++; $display("FAIL round_result[%0d]: got %h expected %h", i, result, vr[i]); end
            checks++; if ({flag_ovf, flag_inv, flag_inx} !== vf[i]) begin errors++; $display("FAIL round_flags[%0d]: got %b expected %b", i, {flag_ovf, flag_inv, flag_inx}, vf[i]); end
         end
         tick();
      end
   endtask

   task automatic test_specials();
      logic [31:0] va [3] = '{32'h7F800000, 32'h7FC00001, 32'hFF800000};
      logic [31:0] vb [3] = '{32'h7F800000, 32'h3F800000, 32'h3F800000};
      logic        vo [3] = '{1'b1, 1'b0, 1'b0};
      logic [31:0] vr [3] = '{32'h7FC00000, 32'h7FC00000, 32'hFF800000};
      logic [2:0]  vf [3] = '{3'b010, 3'b000, 3'b000};
      bit ok;
      for (int i = 0; i < 3; i++) begin
         send_op(va[i], vb[i], vo[i]);
         wait_out(ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL spec_timeout[%0d]: got no out_valid expected one within 10 cycles", i);
         end else begin
            if (result !== vr[i]) begin errors++; $display("FAIL spec_result[%0d]: got %h expected %h", i, result, vr[i]); end
            checks++; if ({flag_ovf, flag_inv, flag_inx} !== vf[i]) begin errors++; $display("FAIL spec_flags[%0d]: got %b expected %b", i, {flag_ovf, flag_inv, flag_inx}, vf[i]); end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] va [6] = '{32'h40C00000, 32'h411C0000, 32'hC0C00000, 32'h3F800000, 32'h40400000, 32'h3F800000};
      logic [31:0] vb [6] = '{32'h41000000, 32'h3F100000, 32'h41000000, 32'h3F800000, 32'h3F800000, 32'h40000000};
      logic [31:0] vr [6] = '{32'h41600000, 32'h41250000, 32'h40000000, 32'h40000000, 32'h40800000, 32'h40400000};
      logic [31:0] exp_q [$];
      logic [31:0] held = '0;
      logic [31:0] got;
      bit holding = 1'b0;
      bit prev_ov = 1'b0;
      int issued = 0;
      int delivered = 0;
      int rise_c = -1;
      for (int i = 0; i < 6; i++) exp_q.push_back(vr[i]);
      op = 1'b0;
      for (int c = 0; c < 80; c++) begin
         if (delivered < 6) begin
            if (holding) begin
               checks++; if (out_valid !== 1'b1 || result !== held) begin errors++; $display("FAIL bp_hold: got valid %b result %h expected valid 1 result %h", out_valid, result, held); end
            end
            out_ready = !(c >= 5 && c < 15);
            in_valid  = (issued < 6);
            if (issued < 6) begin
               a = va[issued];
               b = vb[issued];
            end
            #1;
            if (out_valid && !prev_ov) begin
               rise_c = c;
               checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_drop: got %b expected 0 at cycle %0d", in_ready, c); end
            end
            prev_ov = out_valid;
            if (out_valid && out_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++; $display("FAIL bp_extra: got result %h expected no further result", result);
               end else begin
                  got = exp_q.pop_front();
                  if (result !== got) begin errors++; $display("FAIL bp_result[%0d]: got %h expected %h", delivered, result, got); end
               end
               delivered++;
            end
            holding = out_valid && !out_ready;
            held    = result;
            if (in_valid && in_ready) issued++;
            tick();
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++; if (rise_c != 5) begin errors++; $display("FAIL bp_first_out: got cycle %0d expected 5", rise_c); end
      checks++; if (delivered != 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", delivered); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got out_valid %b expected 0", out_valid); end
   endtask

   task automatic test_reset_midstream();
      int stale = 0;
      bit ok;
      out_ready = 1'b1;
      op        = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = 32'h3F800000;
         b = 32'h3F800000;
         tick();
      end
      in_valid = 1'b0;
      tick();
      rst      = 1'b1;
      in_valid = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
      for (int i = 0; i < 10; i++) begin
         if (out_valid) stale++;
         tick();
      end
      checks++; if (stale != 0) begin errors++; $display("FAIL rst_mid_stale: got %0d stale results expected 0", stale); end
      send_op(32'h40000000, 32'h40000000, 1'b0);
      wait_out(ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL rst_mid_resume: got no out_valid expected one within 10 cycles");
      end else if (result !== 32'h40800000) begin
         errors++; $display("FAIL rst_mid_resume: got %h expected 40800000", result);
      end
      tick();
   endtask

   task automatic test_half();
      logic [15:0] ha [2] = '{16'h3C00, 16'h7BFF};
      logic [15:0] hr [2] = '{16'h4000, 16'h7C00};
      logic [2:0]  hf [2] = '{3'b000, 3'b101};
      bit ok;
      for (int i = 0; i < 2; i++) begin
         h_in_valid = 1'b1;
         h_a        = ha[i];
         h_b        = ha[i];
         tick();
         h_in_valid = 1'b0;
         ok = 1'b0;
         for (int k = 0; k < 10; k++) begin
            if (!ok) begin
               if (h_out_valid) ok = 1'b1;
               else tick();
            end
         end
         checks++;
         if (!ok) begin
            errors++; $display("FAIL half_timeout[%0d]: got no out_valid expected one within 10 cycles", i);
         end else begin
            if (h_result !== hr[i]) begin errors++; $display("FAIL half_result[%0d]: got %h expected %h", i, h_result, hr[i]); end
            checks++; if ({h_flag_ovf, h_flag_inv, h_flag_inx} !== hf[i]) begin errors++; $display("FAIL half_flags[%0d]: got %b expected %b", i, {h_flag_ovf, h_flag_inv, h_flag_inx}, hf[i]); end
         end
         tick();
      end
   endtask

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      op          = 1'b0;
      a           = '0;
      b           = '0;
      out_ready   = 1'b1;
      h_in_valid  = 1'b0;
      h_op        = 1'b0;
      h_a         = '0;
      h_b         = '0;
      h_out_ready = 1'b1;
      test_reset();
      test_back_to_back();
      test_subtract();
      test_rounding();
      test_specials();
      test_backpressure();
      test_reset_midstream();
      test_half();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
